// File: rtl/cart_mem_pkg.sv
// ------------------------------------------------------------------
// cart_mem_pkg: shared widths, FSM state and pending-slot layout.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cart_mem_pkg;

  localparam int ADDR_W     = 22;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slot_t;

endpackage

`default_nettype wire

// File: rtl/cart_mem_if.sv
// ------------------------------------------------------------------
// cart_mem_if: PRG/CHR request ports plus the shared memory port.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface cart_mem_if;
  import cart_mem_pkg::*;

  logic              prg_req;
  logic              prg_we;
  logic [ADDR_W-1:0] prg_addr;
  logic [DATA_W-1:0] prg_wdata;
  logic              chr_req;
  logic              chr_we;
  logic [ADDR_W-1:0] chr_addr;
  logic [DATA_W-1:0] chr_wdata;
  logic              prg_done;
  logic [DATA_W-1:0] prg_rdata;
  logic              chr_done;
  logic [DATA_W-1:0] chr_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              ovf;

  modport slave (
    input  prg_req, prg_we, prg_addr, prg_wdata,
    input  chr_req, chr_we, chr_addr, chr_wdata,
    input  mem_ack, mem_rdata,
    output prg_done, prg_rdata, chr_done, chr_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, ovf
  );

  modport master (
    output prg_req, prg_we, prg_addr, prg_wdata,
    output chr_req, chr_we, chr_addr, chr_wdata,
    output mem_ack, mem_rdata,
    input  prg_done, prg_rdata, chr_done, chr_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, ovf
  );

endinterface

`default_nettype wire

// File: rtl/cart_mem_slot.sv
// ------------------------------------------------------------------
// cart_mem_slot: one-entry pending request holder for a single port.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cart_mem_slot
  import cart_mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  strobe,
  input  slot_t din,
  input  logic  clear,
  output logic  pending,
  output slot_t entry,
  output logic  drop
);

  logic accept;

  // A slot being cleared this edge may be refilled at the same edge.
  assign accept = strobe && (!pending || clear);
  assign drop   = strobe && pending && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      entry   <= '0;
    end else if (accept) begin
      pending <= 1'b1;
      entry   <= din;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cart_mem_seq.sv
// ------------------------------------------------------------------
// cart_mem_seq: arbitrates PRG/CHR cartridge accesses onto one memory
// port. Optional macro CART_MEM_CHR_HIT_EN adds a CHR read-tag bypass.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cart_mem_seq
  import cart_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  cart_mem_if.slave  bus
);

  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

  state_t            state_q, state_d;
  logic              gnt_chr_q, gnt_chr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prg_done_q, chr_done_q, ovf_q;
  logic [DATA_W-1:0] prg_rdata_q, chr_rdata_q;

  logic  prg_pend, chr_pend, prg_drop, chr_drop;
  slot_t prg_entry, chr_entry, cur;
  logic  ack_ok, prg_clear, chr_clear, hit, chr_strobe;
  logic  prg_cand, chr_cand;

  assign ack_ok     = (state_q == BUSY) && bus.mem_ack;
  assign prg_clear  = ack_ok && !gnt_chr_q;
  assign chr_clear  = ack_ok && gnt_chr_q;
  assign chr_strobe = bus.chr_req && !hit;

  cart_mem_slot u_prg_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (bus.prg_req),
    .din     ({bus.prg_we, bus.prg_addr, bus.prg_wdata}),
    .clear   (prg_clear),
    .pending (prg_pend),
    .entry   (prg_entry),
    .drop    (prg_drop)
  );

  cart_mem_slot u_chr_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (chr_strobe),
    .din     ({bus.chr_we, bus.chr_addr, bus.chr_wdata}),
    .clear   (chr_clear),
    .pending (chr_pend),
    .entry   (chr_entry),
    .drop    (chr_drop)
  );

`ifdef CART_MEM_CHR_HIT_EN
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_addr;
  logic              wr_acc;

  // Only an idle CHR slot may bypass, so a hit never collides with an ack.
  assign hit    = bus.chr_req && !bus.chr_we && !chr_pend && tag_valid &&
                  (bus.chr_addr == tag_addr);
  assign wr_acc = (bus.prg_req && bus.prg_we && (!prg_pend || prg_clear)) ||
                  (chr_strobe && bus.chr_we && (!chr_pend || chr_clear));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= 1'b0;
      tag_addr  <= '0;
    end else if (wr_acc) begin
      tag_valid <= 1'b0;
    end else if (chr_clear && !chr_entry.we && !(prg_pend && prg_entry.we)) begin
      tag_valid <= 1'b1;
      tag_addr  <= chr_entry.addr;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Incoming strobes compete directly so a request reaches memory next cycle.
  assign prg_cand = prg_pend || bus.prg_req;
  assign chr_cand = chr_pend || chr_strobe;

  always_comb begin
    state_d   = state_q;
    gnt_chr_d = gnt_chr_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (prg_cand || chr_cand) begin
          state_d = BUSY;
          if (prg_cand && (!chr_cand || cnt_q >= STARVE_CNT)) begin
            gnt_chr_d = 1'b0;
            cnt_d     = '0;
          end else begin
            gnt_chr_d = 1'b1;
            if (!prg_cand)
              cnt_d = '0;
            else if (cnt_q < STARVE_CNT)
              cnt_d = cnt_q + 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_chr_q   <= 1'b0;
      cnt_q       <= '0;
      prg_done_q  <= 1'b0;
      chr_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
      prg_rdata_q <= 8'hFF;
      chr_rdata_q <= 8'hFF;
    end else begin
      state_q    <= state_d;
      gnt_chr_q  <= gnt_chr_d;
      cnt_q      <= cnt_d;
      prg_done_q <= prg_clear;
      chr_done_q <= chr_clear || hit;
      if (prg_clear && !prg_entry.we)
        prg_rdata_q <= bus.mem_rdata;
      if (chr_clear && !chr_entry.we)
        chr_rdata_q <= bus.mem_rdata;
      if (prg_drop || chr_drop)
        ovf_q <= 1'b1;
    end
  end

  assign cur           = gnt_chr_q ? chr_entry : prg_entry;
  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = cur.we;
  assign bus.mem_addr  = cur.addr;
  assign bus.mem_wdata = cur.wdata;
  assign bus.prg_done  = prg_done_q;
  assign bus.chr_done  = chr_done_q;
  assign bus.prg_rdata = prg_rdata_q;
  assign bus.chr_rdata = chr_rdata_q;
  assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire
